// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
package scoreboard_pkg;

  localparam int NUM_REGS    = 16;
  localparam int MAX_PENDING = 3;
  localparam int CNT_W       = $clog2(MAX_PENDING + 1);

  typedef logic [3:0] regCode_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drainState_t;

endpackage

// File: rtl/reg_scoreboard_pending_counter.sv
// Per-register in-flight write counter. Increments on issue, decrements on
// writeback; a simultaneous inc/dec leaves the count unchanged. A decrement at
// zero holds the count at zero and flags underflow for that cycle.
module pending_counter
  import scoreboard_pkg::*;
#(
  parameter int MAX_COUNT = MAX_PENDING,
  parameter int COUNT_W   = CNT_W
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               inc,
  input  logic               dec,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] nextCount,
  output logic               underflow
);

  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] CNT_MAX  = COUNT_W'(MAX_COUNT);

  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] nextCount_s;
  logic               underflow_s;

  // Next count: saturating increment, floored decrement, inc+dec cancel.
  always_comb begin
    nextCount_s = count_r;
    underflow_s = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_r < CNT_MAX) begin
          nextCount_s = count_r + CNT_ONE;
        end else begin
          nextCount_s = count_r;
        end
      end
      2'b01: begin
        if (count_r != CNT_ZERO) begin
          nextCount_s = count_r - CNT_ONE;
        end else begin
          underflow_s = 1'b1;
        end
      end
      default: nextCount_s = count_r;
    endcase
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= nextCount_s;
    end
  end

  assign count     = count_r;
  assign nextCount = nextCount_s;
  assign underflow = underflow_s;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: gates issue against pending writers, retires them at
// writeback, publishes the in-use bitmap and provides a serialising drain.
module reg_scoreboard
  import scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                resetN,
  input  logic                issueValidIn,
  input  regCode_t            issueSrc1In,
  input  regCode_t            issueSrc2In,
  input  logic                issueSrc1ValidIn,
  input  logic                issueSrc2ValidIn,
  input  regCode_t            issueDestIn,
  input  logic                issueDestValidIn,
  input  regCode_t            issueDestSpecialIn,
  input  logic                issueDestSpecialValidIn,
  output logic                issueGrantOut,
  input  logic                wbValidIn,
  input  regCode_t            wbDestIn,
  input  logic                wbDestValidIn,
  input  regCode_t            wbDestSpecialIn,
  input  logic                wbDestSpecialValidIn,
  input  logic                drainReqIn,
  output logic                drainDoneOut,
  output logic [NUM_REGS-1:0] regInUseBitMapOut,
  output logic                underflowErrOut
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0]    counts_s     [NUM_REGS];
  logic [CNT_W-1:0]    nextCounts_s [NUM_REGS];
  logic [NUM_REGS-1:0] incVec_s;
  logic [NUM_REGS-1:0] decVec_s;
  logic [NUM_REGS-1:0] underflowVec_s;
  logic [NUM_REGS-1:0] nextZeroVec_s;
  logic                allZeroNext_s;
  logic                srcBlocked_s;
  logic                destFull_s;
  logic                grant_s;
  drainState_t         state_r;
  drainState_t         nextState_s;
  logic                drainDone_r;
  logic                underflow_r;
  logic [NUM_REGS-1:0] inUse_r;

  // Issue grant: no bypass from same-cycle writeback, sources must be idle,
  // destinations must have headroom, and nothing issues outside RUN.
  always_comb begin
    srcBlocked_s = (issueSrc1ValidIn && (counts_s[issueSrc1In] != CNT_ZERO)) ||
                   (issueSrc2ValidIn && (counts_s[issueSrc2In] != CNT_ZERO));
    destFull_s   = (issueDestValidIn        && (counts_s[issueDestIn]        >= CNT_MAX)) ||
                   (issueDestSpecialValidIn && (counts_s[issueDestSpecialIn] >= CNT_MAX));
    grant_s      = issueValidIn && (state_r == RUN) && !srcBlocked_s && !destFull_s;
  end

  // Per-register inc/dec strobes; matching both destinations still yields one strobe.
  always_comb begin
    incVec_s = {NUM_REGS{1'b0}};
    decVec_s = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      incVec_s[r] = grant_s &&
                    ((issueDestValidIn        && (issueDestIn        == regCode_t'(r))) ||
                     (issueDestSpecialValidIn && (issueDestSpecialIn == regCode_t'(r))));
      decVec_s[r] = wbValidIn &&
                    ((wbDestValidIn        && (wbDestIn        == regCode_t'(r))) ||
                     (wbDestSpecialValidIn && (wbDestSpecialIn == regCode_t'(r))));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gen_counter
    pending_counter #(
      .MAX_COUNT (MAX_PENDING),
      .COUNT_W   (CNT_W)
    ) u_counter (
      .clk       (clk),
      .resetN    (resetN),
      .inc       (incVec_s[g]),
      .dec       (decVec_s[g]),
      .count     (counts_s[g]),
      .nextCount (nextCounts_s[g]),
      .underflow (underflowVec_s[g])
    );
    assign nextZeroVec_s[g] = (nextCounts_s[g] == CNT_ZERO);
  end

  assign allZeroNext_s = &nextZeroVec_s;

  // Drain FSM next state: DRAIN waits for the post-update counts to all be zero.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      RUN: begin
        if (drainReqIn) begin
          nextState_s = DRAIN;
        end else begin
          nextState_s = RUN;
        end
      end
      DRAIN: begin
        if (allZeroNext_s) begin
          nextState_s = DONE;
        end else begin
          nextState_s = DRAIN;
        end
      end
      DONE:    nextState_s = RUN;
      default: nextState_s = RUN;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r <= RUN;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Registered status outputs: done pulse, in-use bitmap, sticky underflow.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      drainDone_r <= 1'b0;
      inUse_r     <= {NUM_REGS{1'b0}};
      underflow_r <= 1'b0;
    end else begin
      drainDone_r <= (nextState_s == DONE);
      inUse_r     <= ~nextZeroVec_s;
      underflow_r <= underflow_r | (|underflowVec_s);
    end
  end

  assign issueGrantOut     = grant_s;
  assign drainDoneOut      = drainDone_r;
  assign regInUseBitMapOut = inUse_r;
  assign underflowErrOut   = underflow_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: driver issues stimulus and queues per-cycle expectations
// from a count-array reference model; a negedge monitor pops and compares.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        resetN;
  logic        issueValidIn;
  logic [3:0]  issueSrc1In, issueSrc2In, issueDestIn, issueDestSpecialIn;
  logic        issueSrc1ValidIn, issueSrc2ValidIn, issueDestValidIn, issueDestSpecialValidIn;
  logic        issueGrantOut;
  logic        wbValidIn;
  logic [3:0]  wbDestIn, wbDestSpecialIn;
  logic        wbDestValidIn, wbDestSpecialValidIn;
  logic        drainReqIn;
  logic        drainDoneOut;
  logic [15:0] regInUseBitMapOut;
  logic        underflowErrOut;

  reg_scoreboard dut (
    .clk                     (clk),
    .resetN                  (resetN),
    .issueValidIn            (issueValidIn),
    .issueSrc1In             (issueSrc1In),
    .issueSrc2In             (issueSrc2In),
    .issueSrc1ValidIn        (issueSrc1ValidIn),
    .issueSrc2ValidIn        (issueSrc2ValidIn),
    .issueDestIn             (issueDestIn),
    .issueDestValidIn        (issueDestValidIn),
    .issueDestSpecialIn      (issueDestSpecialIn),
    .issueDestSpecialValidIn (issueDestSpecialValidIn),
    .issueGrantOut           (issueGrantOut),
    .wbValidIn               (wbValidIn),
    .wbDestIn                (wbDestIn),
    .wbDestValidIn           (wbDestValidIn),
    .wbDestSpecialIn         (wbDestSpecialIn),
    .wbDestSpecialValidIn    (wbDestSpecialValidIn),
    .drainReqIn              (drainReqIn),
    .drainDoneOut            (drainDoneOut),
    .regInUseBitMapOut       (regInUseBitMapOut),
    .underflowErrOut         (underflowErrOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] s1, s2, d, ds;
    logic       s1v, s2v, dv, dsv;
    logic       wv;
    logic [3:0] wd, wds;
    logic       wdv, wdsv;
    logic       drain;
  } stim_t;

  typedef struct {
    logic        grant;
    logic        done;
    logic [15:0] map;
    logic        uf;
  } exp_t;

  exp_t expQ[$];

  // Reference model: pending writes per register plus drain bookkeeping.
  int cnt[16];
  bit draining;
  bit doneNow;
  bit ufSticky;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, iv: 1'b0, s1: 4'd0, s2: 4'd0, d: 4'd0, ds: 4'd0,
          s1v: 1'b0, s2v: 1'b0, dv: 1'b0, dsv: 1'b0, wv: 1'b0, wd: 4'd0,
          wds: 4'd0, wdv: 1'b0, wdsv: 1'b0, drain: 1'b0};
    return s;
  endfunction

  function automatic stim_t issueDest(input logic [3:0] r);
    stim_t s;
    s = idle();
    s.iv = 1'b1; s.d = r; s.dv = 1'b1;
    return s;
  endfunction

  function automatic stim_t issueSrc(input logic [3:0] r);
    stim_t s;
    s = idle();
    s.iv = 1'b1; s.s1 = r; s.s1v = 1'b1;
    return s;
  endfunction

  function automatic stim_t wbOnly(input logic [3:0] r);
    stim_t s;
    s = idle();
    s.wv = 1'b1; s.wd = r; s.wdv = 1'b1;
    return s;
  endfunction

  // One clock of stimulus: drive, queue expectation, advance the model.
  task automatic step(input stim_t s);
    exp_t e;
    bit   up[16];
    bit   dn[16];
    bit   allZero;
    @(posedge clk);
    #1;
    resetN = s.rst; issueValidIn = s.iv;
    issueSrc1In = s.s1; issueSrc1ValidIn = s.s1v;
    issueSrc2In = s.s2; issueSrc2ValidIn = s.s2v;
    issueDestIn = s.d; issueDestValidIn = s.dv;
    issueDestSpecialIn = s.ds; issueDestSpecialValidIn = s.dsv;
    wbValidIn = s.wv; wbDestIn = s.wd; wbDestValidIn = s.wdv;
    wbDestSpecialIn = s.wds; wbDestSpecialValidIn = s.wdsv;
    drainReqIn = s.drain;

    e.map = 16'h0000;
    for (int r = 0; r < 16; r++) e.map[r] = (cnt[r] != 0);
    e.uf    = ufSticky;
    e.done  = doneNow;
    e.grant = s.iv && !draining && !doneNow &&
              !(s.s1v && cnt[s.s1] != 0) && !(s.s2v && cnt[s.s2] != 0) &&
              !(s.dv && cnt[s.d] >= 3) && !(s.dsv && cnt[s.ds] >= 3);
    expQ.push_back(e);

    if (!s.rst) begin
      for (int r = 0; r < 16; r++) cnt[r] = 0;
      draining = 1'b0; doneNow = 1'b0; ufSticky = 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) begin up[r] = 1'b0; dn[r] = 1'b0; end
      if (e.grant && s.dv)  up[s.d]  = 1'b1;
      if (e.grant && s.dsv) up[s.ds] = 1'b1;
      if (s.wv && s.wdv)    dn[s.wd]  = 1'b1;
      if (s.wv && s.wdsv)   dn[s.wds] = 1'b1;
      for (int r = 0; r < 16; r++) begin
        if (up[r] && dn[r]) begin
        end else if (up[r]) begin
          cnt[r]++;
        end else if (dn[r]) begin
          if (cnt[r] == 0) ufSticky = 1'b1;
          else cnt[r]--;
        end
      end
      allZero = 1'b1;
      for (int r = 0; r < 16; r++) if (cnt[r] != 0) allZero = 1'b0;
      if (doneNow) doneNow = 1'b0;
      else if (draining) begin
        if (allZero) begin draining = 1'b0; doneNow = 1'b1; end
      end else if (s.drain) draining = 1'b1;
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("grant", {15'd0, issueGrantOut}, {15'd0, e.grant});
      check("drainDone", {15'd0, drainDoneOut}, {15'd0, e.done});
      check("inUseMap", regInUseBitMapOut, e.map);
      check("underflow", {15'd0, underflowErrOut}, {15'd0, e.uf});
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    int    r;
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    draining = 1'b0; doneNow = 1'b0; ufSticky = 1'b0;
    s = idle();
    resetN = 1'b0; issueValidIn = 1'b0;
    issueSrc1In = 4'd0; issueSrc2In = 4'd0; issueDestIn = 4'd0; issueDestSpecialIn = 4'd0;
    issueSrc1ValidIn = 1'b0; issueSrc2ValidIn = 1'b0;
    issueDestValidIn = 1'b0; issueDestSpecialValidIn = 1'b0;
    wbValidIn = 1'b0; wbDestIn = 4'd0; wbDestSpecialIn = 4'd0;
    wbDestValidIn = 1'b0; wbDestSpecialValidIn = 1'b0; drainReqIn = 1'b0;
    repeat (2) @(posedge clk);

    // Basic hazard on R3.
    step(idle());
    step(issueDest(4'd3));
    step(issueSrc(4'd3));
    step(wbOnly(4'd3));
    step(issueSrc(4'd3));

    // Saturation on R5.
    repeat (4) step(issueDest(4'd5));
    step(wbOnly(4'd5));
    step(issueDest(4'd5));
    repeat (3) step(wbOnly(4'd5));

    // Simultaneous grant and writeback on R7 with count 1.
    step(issueDest(4'd7));
    s = issueDest(4'd7); s.wv = 1'b1; s.wd = 4'd7; s.wdv = 1'b1;
    step(s);
    step(wbOnly(4'd7));

    // Dedup of both destinations on R2.
    s = issueDest(4'd2); s.ds = 4'd2; s.dsv = 1'b1;
    step(s);
    s = wbOnly(4'd2); s.wds = 4'd2; s.wdsv = 1'b1;
    step(s);
    step(issueSrc(4'd2));

    // Drain with R1 and R4 pending.
    step(issueDest(4'd1));
    step(issueDest(4'd4));
    s = issueSrc(4'd0); s.drain = 1'b1;
    step(s);
    step(issueSrc(4'd0));
    step(wbOnly(4'd1));
    step(issueSrc(4'd0));
    step(wbOnly(4'd4));
    repeat (3) step(issueSrc(4'd0));

    // Drain with nothing pending.
    s = idle(); s.drain = 1'b1;
    step(s);
    repeat (3) step(issueSrc(4'd0));

    // Underflow, then reset in the middle of a drain.
    step(wbOnly(4'd9));
    step(idle());
    step(issueDest(4'd6));
    s = idle(); s.drain = 1'b1;
    step(s);
    step(idle());
    s = idle(); s.rst = 1'b0;
    step(s);
    repeat (3) step(issueSrc(4'd6));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst  = ($urandom_range(0, 299) != 0);
      s.iv   = ($urandom_range(0, 3) != 0);
      s.s1   = 4'($urandom_range(0, 15));
      s.s1v  = ($urandom_range(0, 2) == 0);
      s.s2   = 4'($urandom_range(0, 15));
      s.s2v  = ($urandom_range(0, 3) == 0);
      s.d    = 4'($urandom_range(0, 15));
      s.dv   = ($urandom_range(0, 3) != 0);
      s.ds   = ($urandom_range(0, 3) == 0) ? s.d : 4'($urandom_range(0, 15));
      s.dsv  = ($urandom_range(0, 3) == 0);
      s.wv   = ($urandom_range(0, 1) == 0);
      r = $urandom_range(0, 15);
      s.wd   = 4'(r);
      s.wdv  = (cnt[r] != 0) || ($urandom_range(0, 31) == 0);
      r = $urandom_range(0, 15);
      s.wds  = ($urandom_range(0, 3) == 0) ? s.wd : 4'(r);
      s.wdsv = ($urandom_range(0, 2) == 0) && ((cnt[s.wds] != 0) || ($urandom_range(0, 31) == 0));
      s.drain = ($urandom_range(0, 39) == 0);
      step(s);
    end

    @(negedge clk);
    #1;
    check("queueEmpty", 16'(expQ.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
